// File: rtl/fl_mux_sched_pkg.sv
// Shared types and constants for the fl_mux_sched write scheduler.
package fl_mux_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } state_e;

    localparam int unsigned BURST_MAX_DEF = 4;
    localparam int unsigned BURST_W       = 4;

endpackage

// File: rtl/fl_mux_reg.sv
// WIDTH-bit register bank with a 2:1 input mux and clock enable.
module fl_mux_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CK,
    input  logic             SR,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    input  logic             SD,
    input  logic             SP,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (SP) begin
            q_d = SD ? D1 : D0;
        end
    end

    always_ff @(posedge CK or posedge SR) begin
        if (SR) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/fl_mux_sched.sv
// Two-requester round-robin write scheduler driving a mux-enable register bank.
// Optional burst locking is enabled by defining FL_MUX_SCHED_LOCK_EN.
module fl_mux_sched
    import fl_mux_sched_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned BURST_MAX = BURST_MAX_DEF
) (
    input  logic             CK,
    input  logic             SR,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    input  logic             HOLD,
    input  logic             LOCK,
    output logic             GNT0,
    output logic             GNT1,
    output logic             SD,
    output logic             SP,
    output logic [WIDTH-1:0] Q
);

    state_e state_q;
    state_e state_d;
    state_e rr_next;
    logic   last_q;
    logic   last_d;

    // Plain round-robin choice; LAST names the requester granted most recently.
    always_comb begin
        rr_next = IDLE;
        if (REQ0 && REQ1) begin
            rr_next = last_q ? G0 : G1;
        end else if (REQ0) begin
            rr_next = G0;
        end else if (REQ1) begin
            rr_next = G1;
        end
    end

`ifdef FL_MUX_SCHED_LOCK_EN
    localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);
    localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(BURST_MAX);

    logic [BURST_W-1:0] burst_q;
    logic [BURST_W-1:0] burst_d;
    logic               own_req;
    logic               other_req;
    logic               keep;

    always_comb begin
        own_req   = (state_q == G0) ? REQ0 : ((state_q == G1) ? REQ1 : 1'b0);
        other_req = (state_q == G0) ? REQ1 : ((state_q == G1) ? REQ0 : 1'b0);
        // Lock keeps the grant until the burst limit, and beyond it only if nobody else waits.
        keep      = LOCK && own_req && ((burst_q < BURST_LIM) || !other_req);

        state_d = rr_next;
        burst_d = (rr_next == IDLE) ? '0 : BURST_ONE;
        if (HOLD) begin
            state_d = IDLE;
            burst_d = '0;
        end else if (keep) begin
            state_d = state_q;
            burst_d = (burst_q < BURST_LIM) ? burst_q + BURST_ONE : burst_q;
        end
    end

    always_ff @(posedge CK or posedge SR) begin
        if (SR) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`else
    logic lock_unused;

    assign lock_unused = LOCK;

    always_comb begin
        state_d = rr_next;
        if (HOLD) begin
            state_d = IDLE;
        end
    end
`endif

    always_comb begin
        last_d = last_q;
        if (state_d == G0) begin
            last_d = 1'b0;
        end else if (state_d == G1) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge CK or posedge SR) begin
        if (SR) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    assign GNT0 = (state_q == G0);
    assign GNT1 = (state_q == G1);
    assign SD   = GNT1;
    assign SP   = GNT0 | GNT1;

    fl_mux_reg #(
        .WIDTH(WIDTH)
    ) u_reg (
        .CK(CK),
        .SR(SR),
        .D0(D0),
        .D1(D1),
        .SD(SD),
        .SP(SP),
        .Q (Q)
    );

endmodule

// File: tb/tb_fl_mux_sched.sv
// Self-checking bench for fl_mux_sched; lock expectations follow FL_MUX_SCHED_LOCK_EN.
module tb_fl_mux_sched;

    typedef struct {
        logic       g0;
        logic       g1;
        logic [7:0] q;
    } exp_t;

    logic       CK = 1'b0;
    logic       SR = 1'b1;
    logic       REQ0 = 1'b0;
    logic       REQ1 = 1'b0;
    logic [7:0] D0 = '0;
    logic [7:0] D1 = '0;
    logic       HOLD = 1'b0;
    logic       LOCK = 1'b0;
    logic       GNT0;
    logic       GNT1;
    logic       SD;
    logic       SP;
    logic [7:0] Q;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    fl_mux_sched #(
        .WIDTH(8),
        .BURST_MAX(4)
    ) dut (
        .CK(CK),
        .SR(SR),
        .REQ0(REQ0),
        .REQ1(REQ1),
        .D0(D0),
        .D1(D1),
        .HOLD(HOLD),
        .LOCK(LOCK),
        .GNT0(GNT0),
        .GNT1(GNT1),
        .SD(SD),
        .SP(SP),
        .Q(Q)
    );

    always #5 CK = ~CK;

    initial begin
        #100000;
        $display("FAIL watchdog: sim time limit reached, got=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic reset_dut();
        @(negedge CK);
        SR = 1'b1;
        REQ0 = 1'b0; REQ1 = 1'b0; HOLD = 1'b0; LOCK = 1'b0;
        @(negedge CK);
        SR = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({GNT0, GNT1, SD, SP} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b required=0000", {GNT0, GNT1, SD, SP});
        end
        total++;
        if (Q !== 8'h00) begin
            bad++;
            $display("FAIL reset_q got=%h required=00", Q);
        end
    endtask

    task automatic test_single();
        exp_t e;
        reset_dut();
        sb.push_back('{g0: 1'b1, g1: 1'b0, q: 8'h00});
        sb.push_back('{g0: 1'b0, g1: 1'b0, q: 8'h3C});
        REQ0 = 1'b1; D0 = 8'h3C;
        for (int k = 1; k <= 2; k++) begin
            @(posedge CK); #1;
            e = sb.pop_front();
            total++;
            if ({GNT0, GNT1} !== {e.g0, e.g1}) begin
                bad++;
                $display("FAIL single_gnt cyc%0d got=%b%b required=%b%b", k, GNT0, GNT1, e.g0, e.g1);
            end
            total++;
            if ({SD, SP} !== {e.g1, e.g0 | e.g1}) begin
                bad++;
                $display("FAIL single_sdsp cyc%0d got=%b%b required=%b%b", k, SD, SP, e.g1, e.g0 | e.g1);
            end
            total++;
            if (Q !== e.q) begin
                bad++;
                $display("FAIL single_q cyc%0d got=%h required=%h", k, Q, e.q);
            end
            if (k == 1) begin
                @(negedge CK);
                REQ0 = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        reset_dut();
        for (int k = 1; k <= 7; k++) begin
            e.g0 = (k <= 6) && (k % 2 == 1);
            e.g1 = (k <= 6) && (k % 2 == 0);
            e.q  = (k == 1) ? 8'h00 : ((k % 2 == 0) ? 8'h11 : 8'h22);
            sb.push_back(e);
        end
        REQ0 = 1'b1; REQ1 = 1'b1; D0 = 8'h11; D1 = 8'h22;
        for (int k = 1; k <= 7; k++) begin
            @(posedge CK); #1;
            e = sb.pop_front();
            total++;
            if ({GNT0, GNT1} !== {e.g0, e.g1}) begin
                bad++;
                $display("FAIL b2b_gnt cyc%0d got=%b%b required=%b%b", k, GNT0, GNT1, e.g0, e.g1);
            end
            total++;
            if ({SD, SP} !== {e.g1, e.g0 | e.g1}) begin
                bad++;
                $display("FAIL b2b_sdsp cyc%0d got=%b%b required=%b%b", k, SD, SP, e.g1, e.g0 | e.g1);
            end
            total++;
            if (Q !== e.q) begin
                bad++;
                $display("FAIL b2b_q cyc%0d got=%h required=%h", k, Q, e.q);
            end
            if (k == 6) begin
                @(negedge CK);
                REQ0 = 1'b0; REQ1 = 1'b0;
            end
        end
    endtask

    // Runs straight after test_back_to_back: LAST=1 and Q=22 on entry.
    task automatic test_hold();
        exp_t e;
        for (int k = 1; k <= 6; k++) begin
            e.g0 = (k == 4);
            e.g1 = (k == 5);
            e.q  = (k <= 4) ? 8'h22 : ((k == 5) ? 8'h33 : 8'h44);
            sb.push_back(e);
        end
        @(negedge CK);
        REQ0 = 1'b1; REQ1 = 1'b1; HOLD = 1'b1; D0 = 8'h33; D1 = 8'h44;
        for (int k = 1; k <= 6; k++) begin
            @(posedge CK); #1;
            e = sb.pop_front();
            total++;
            if ({GNT0, GNT1} !== {e.g0, e.g1}) begin
                bad++;
                $display("FAIL hold_gnt cyc%0d got=%b%b required=%b%b", k, GNT0, GNT1, e.g0, e.g1);
            end
            total++;
            if (SP !== (e.g0 | e.g1)) begin
                bad++;
                $display("FAIL hold_sp cyc%0d got=%b required=%b", k, SP, e.g0 | e.g1);
            end
            total++;
            if (Q !== e.q) begin
                bad++;
                $display("FAIL hold_q cyc%0d got=%h required=%h", k, Q, e.q);
            end
            if (k == 3) begin
                @(negedge CK);
                HOLD = 1'b0;
            end else if (k == 5) begin
                @(negedge CK);
                REQ0 = 1'b0; REQ1 = 1'b0;
            end
        end
    endtask

    // Request raised only while held, then withdrawn: must never be granted later.
    task automatic test_drop();
        exp_t e;
        for (int k = 1; k <= 3; k++) begin
            sb.push_back('{g0: 1'b0, g1: 1'b0, q: 8'h44});
        end
        @(negedge CK);
        REQ1 = 1'b1; HOLD = 1'b1; D1 = 8'h99;
        for (int k = 1; k <= 3; k++) begin
            @(posedge CK); #1;
            e = sb.pop_front();
            total++;
            if ({GNT0, GNT1} !== {e.g0, e.g1}) begin
                bad++;
                $display("FAIL drop_gnt cyc%0d got=%b%b required=%b%b", k, GNT0, GNT1, e.g0, e.g1);
            end
            total++;
            if (Q !== e.q) begin
                bad++;
                $display("FAIL drop_q cyc%0d got=%h required=%h", k, Q, e.q);
            end
            if (k == 1) begin
                @(negedge CK);
                REQ1 = 1'b0; HOLD = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        REQ0 = 1'b1; D0 = 8'hA5;
        @(posedge CK); #1;
        total++;
        if (GNT0 !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_gnt_before got=%b required=1", GNT0);
        end
        #2;
        SR = 1'b1;
        #1;
        total++;
        if ({GNT0, SP} !== 2'b00) begin
            bad++;
            $display("FAIL rstmid_gnt_async got=%b%b required=00", GNT0, SP);
        end
        total++;
        if (Q !== 8'h00) begin
            bad++;
            $display("FAIL rstmid_q_async got=%h required=00", Q);
        end
        @(posedge CK); #1;
        total++;
        if (Q !== 8'h00) begin
            bad++;
            $display("FAIL rstmid_q_after_edge got=%h required=00", Q);
        end
        @(negedge CK);
        SR = 1'b0; REQ0 = 1'b0;
        @(posedge CK); #1;
        total++;
        if ({GNT0, GNT1, Q} !== {2'b00, 8'h00}) begin
            bad++;
            $display("FAIL rstmid_idle got=%b%b/%h required=00/00", GNT0, GNT1, Q);
        end
    endtask

    task automatic test_lock();
        exp_t       e;
        logic [5:0] g0s;
        logic [7:0] qs [0:6];
`ifdef FL_MUX_SCHED_LOCK_EN
        g0s = 6'b001111;
        qs  = '{8'h00, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22};
`else
        g0s = 6'b010101;
        qs  = '{8'h00, 8'h11, 8'h22, 8'h11, 8'h22, 8'h11, 8'h22};
`endif
        reset_dut();
        for (int k = 1; k <= 7; k++) begin
            e.g0 = (k <= 6) ? g0s[k-1] : 1'b0;
            e.g1 = (k <= 6) ? ~g0s[k-1] : 1'b0;
            e.q  = qs[k-1];
            sb.push_back(e);
        end
        LOCK = 1'b1; REQ0 = 1'b1; REQ1 = 1'b1; D0 = 8'h11; D1 = 8'h22;
        for (int k = 1; k <= 7; k++) begin
            @(posedge CK); #1;
            e = sb.pop_front();
            total++;
            if ({GNT0, GNT1} !== {e.g0, e.g1}) begin
                bad++;
                $display("FAIL lock_gnt cyc%0d got=%b%b required=%b%b", k, GNT0, GNT1, e.g0, e.g1);
            end
            total++;
            if (Q !== e.q) begin
                bad++;
                $display("FAIL lock_q cyc%0d got=%h required=%h", k, Q, e.q);
            end
            if (k == 6) begin
                @(negedge CK);
                REQ0 = 1'b0; REQ1 = 1'b0; LOCK = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_drop();
        test_reset_mid();
        test_lock();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
